// File: rtl/ercm_acc_pkg.sv
// ercm_acc_pkg: shared state encoding, product width and vector-length normalisation
package ercm_acc_pkg;
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
    localparam int PROD_W = 16;
    // A programmed length of 0 means a one-beat vector.
    function automatic logic [31:0] len_norm(input logic [31:0] l);
        return (l == 32'd0) ? 32'd1 : l;
    endfunction
endpackage

// File: rtl/ercm_acc_add.sv
// ercm_acc_add: ACC_W-bit accumulate adder with carry out; clamps to all-ones when ERCM_ACC_SAT_EN is defined
// ports: a (running sum), b (16-bit product), sum (next sum), co (carry out of ACC_W bits)
module ercm_acc_add
    import ercm_acc_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              co
);
    logic [ACC_W:0] full;
    assign full = {1'b0, a} + (ACC_W+1)'(b);
    assign co   = full[ACC_W];
`ifdef ERCM_ACC_SAT_EN
    // Once clamped, any further nonzero beat carries again, so the sum sticks at max.
    assign sum  = co ? '1 : full[ACC_W-1:0];
`else
    assign sum  = full[ACC_W-1:0];
`endif
endmodule

// File: rtl/ercm8_prod_acc.sv
// ercm8_prod_acc: accumulates cfg_len product beats into one dot-product result with overflow flags
// ports: clk/rst (sync active-high), clr (abort, keeps ovf_sticky), cfg_len (beats per vector, 0 = 1),
//        in_vld/in_rdy/in_dat (product stream), out_vld/out_rdy/out_dat/out_ovf (result), ovf_sticky, busy
// macro: ERCM_ACC_SAT_EN selects saturating instead of wrapping accumulation
module ercm8_prod_acc
    import ercm_acc_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic              clr,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [PROD_W-1:0] in_dat,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [ACC_W-1:0]  out_dat,
    output logic              out_ovf,
    output logic              ovf_sticky,
    output logic              busy
);
    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d, len_in;
    logic             ovf_cur_q, ovf_cur_d, sticky_q, sticky_d, co, take;

    ercm_acc_add #(.ACC_W(ACC_W)) u_add (.a(acc_q), .b(in_dat), .sum(sum), .co(co));

    assign len_in     = CNT_W'(len_norm(32'(cfg_len)));
    // in_rdy is held low through the reset cycle itself.
    assign in_rdy     = ~rst & (state_q != HOLD);
    assign take       = in_vld & in_rdy;
    assign out_vld    = state_q == HOLD;
    assign out_dat    = acc_q;
    assign out_ovf    = ovf_cur_q;
    assign ovf_sticky = sticky_q;
    assign busy       = state_q != IDLE;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        ovf_cur_d = ovf_cur_q;
        sticky_d  = sticky_q;
        case (state_q)
            IDLE: if (take) begin
                acc_d     = ACC_W'(in_dat);
                cnt_d     = CNT_W'(1);
                len_d     = len_in;
                ovf_cur_d = 1'b0;
                state_d   = (len_in == CNT_W'(1)) ? HOLD : ACC;
            end
            ACC: if (take) begin
                acc_d     = sum;
                ovf_cur_d = ovf_cur_q | co;
                sticky_d  = sticky_q | co;
                cnt_d     = cnt_q + CNT_W'(1);
                state_d   = (cnt_d == len_q) ? HOLD : ACC;
            end
            HOLD: state_d = out_rdy ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
        // Abort beats any same-cycle accept; the sticky flag survives it.
        if (clr) begin
            state_d   = IDLE;
            acc_d     = '0;
            cnt_d     = '0;
            len_d     = '0;
            ovf_cur_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            ovf_cur_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            ovf_cur_q <= ovf_cur_d;
            sticky_q  <= sticky_d;
        end
    end
endmodule

// File: tb/tb_ercm8_prod_acc.sv
// tb_ercm8_prod_acc: directed checks of the product accumulator built with a 16-bit accumulator
module tb_ercm8_prod_acc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cfg_len = '0;
    logic        clr = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [15:0] in_dat = '0;
    logic        out_vld;
    logic        out_rdy = 1'b0;
    logic [15:0] out_dat;
    logic        out_ovf;
    logic        ovf_sticky;
    logic        busy;
    int          checks = 0;
    int          failures = 0;

    ercm8_prod_acc #(.ACC_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .clr(clr),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat),
        .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one beat and hold it until accepted, with a bounded wait.
    task automatic send(input logic [15:0] d);
        int n;
        in_vld = 1'b1;
        in_dat = d;
        n = 0;
        while (!in_rdy && n < 20) begin
            step();
            n++;
        end
        if (!in_rdy) begin
            failures++;
            $error("FAIL send_timeout got=%0h exp=%0h", in_rdy, 1'b1);
        end
        step();
        in_vld = 1'b0;
    endtask

    initial begin
        logic [15:0] sum;
        logic [15:0] d;
        step();
        chk("rst_in_rdy", in_rdy, 0);
        step();
        chk("rst_out_vld", out_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sticky", ovf_sticky, 0);
        chk("rst_out_ovf", out_ovf, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_rdy", in_rdy, 1);

        cfg_len = 8'd4;
        out_rdy = 1'b1;
        send(16'd100);
        chk("v1_busy", busy, 1);
        send(16'd200);
        send(16'd300);
        chk("v1_not_done", out_vld, 0);
        send(16'd400);
        chk("v1_out_vld", out_vld, 1);
        chk("v1_out_dat", out_dat, 1000);
        chk("v1_out_ovf", out_ovf, 0);
        chk("v1_in_rdy_hold", in_rdy, 0);
        step();
        chk("v1_after_vld", out_vld, 0);
        chk("v1_after_rdy", in_rdy, 1);

        cfg_len = 8'd0;
        send(16'hFFFF);
        chk("v2_out_vld", out_vld, 1);
        chk("v2_out_dat", out_dat, 65535);
        chk("v2_out_ovf", out_ovf, 0);
        step();

        cfg_len = 8'd2;
        send(16'hFFFF);
        chk("v3_mid_sticky", ovf_sticky, 0);
        send(16'd2);
        chk("v3_out_vld", out_vld, 1);
`ifdef ERCM_ACC_SAT_EN
        chk("v3_out_dat", out_dat, 16'hFFFF);
`else
        chk("v3_out_dat", out_dat, 1);
`endif
        chk("v3_out_ovf", out_ovf, 1);
        chk("v3_sticky", ovf_sticky, 1);
        step();
        cfg_len = 8'd1;
        send(16'd5);
        chk("v4_out_dat", out_dat, 5);
        chk("v4_out_ovf", out_ovf, 0);
        chk("v4_sticky", ovf_sticky, 1);
        step();

        out_rdy = 1'b0;
        send(16'd42);
        in_vld = 1'b1;
        in_dat = 16'd99;
        for (int i = 0; i < 5; i++) begin
            chk("stall_vld", out_vld, 1);
            chk("stall_dat", out_dat, 42);
            chk("stall_in_rdy", in_rdy, 0);
            step();
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        step();
        chk("stall_released", out_vld, 0);
        chk("stall_no_beat", busy, 0);
        chk("stall_in_rdy_back", in_rdy, 1);

        cfg_len = 8'd4;
        send(16'd50);
        send(16'd60);
        clr = 1'b1;
        in_vld = 1'b1;
        in_dat = 16'd70;
        step();
        clr = 1'b0;
        in_vld = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_out_vld", out_vld, 0);
        chk("clr_keeps_sticky", ovf_sticky, 1);
        cfg_len = 8'd2;
        send(16'd7);
        chk("clr_no_early", out_vld, 0);
        send(16'd8);
        chk("clr_vld", out_vld, 1);
        chk("clr_dat", out_dat, 15);
        step();
        chk("clr_single", out_vld, 0);

        cfg_len = 8'd3;
        for (int v = 0; v < 50; v++) begin
            sum = '0;
            for (int b = 0; b < 3; b++) begin
                repeat ($urandom_range(0, 2)) step();
                d = 16'($urandom_range(0, 5000));
                sum += d;
                send(d);
                if (b < 2) chk("rnd_no_early", out_vld, 0);
            end
            out_rdy = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                chk("rnd_hold_dat", out_dat, sum);
                step();
            end
            out_rdy = 1'b1;
            chk("rnd_vld", out_vld, 1);
            chk("rnd_dat", out_dat, sum);
            step();
            chk("rnd_no_dup", out_vld, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
